// File: rtl/bc_mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, transaction owner
// and the latched memory command.
package bc_mem_arb_pkg;

  localparam int unsigned CMD_AW = 32;
  localparam int unsigned CMD_DW = 32;

  localparam int unsigned GNT_F = 0;
  localparam int unsigned GNT_D = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } mem_cmd_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bc_arb_prio.sv
// Grant selection for the arbiter: data wins unless fetch has waited through
// MAX_DATA_BURST data grants.
module bc_arb_prio
  import bc_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_idle,
  input  logic       i_f_req,
  input  logic       i_d_req,
  output logic [1:0] o_gnt
);

  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       starve;

  assign starve = i_f_req && (burst_cnt_q == 4'(MAX_DATA_BURST));

  always_comb begin
    o_gnt = '0;
    if (i_idle) begin
      if (i_f_req && (starve || !i_d_req)) o_gnt[GNT_F] = 1'b1;
      else if (i_d_req)                    o_gnt[GNT_D] = 1'b1;
    end
  end

  // Counts only data grants that made fetch wait; any IDLE cycle without a
  // fetch request means fetch is not starving, so the count restarts.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (i_idle) begin
      if (!i_f_req || o_gnt[GNT_F]) burst_cnt_d = '0;
      else if (o_gnt[GNT_D])        burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) burst_cnt_q <= '0;
    else         burst_cnt_q <= burst_cnt_d;
  end

endmodule

// File: rtl/bc_mem_arbiter.sv
// Shares one word-addressed memory port between instruction fetch (read-only)
// and load/store data; one transaction outstanding, read timeout recovery.
//
//   state | meaning
//   IDLE  | arbitrate, pulse gnt, latch command
//   ISSUE | memory command strobes active for one cycle
//   WAIT  | read outstanding, timeout counter running
module bc_mem_arbiter
  import bc_mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = CMD_DW,
  parameter int unsigned ADDR_WIDTH     = CMD_AW,
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_f_req,
  input  logic [ADDR_WIDTH-1:0] i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [DATA_WIDTH-1:0] o_f_rdata,
  output logic                  o_f_rerr,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic                  o_d_rerr,
  output logic                  o_mem_ren,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_rdata_valid,
  output logic                  o_mem_wen,
  output logic                  o_mem_wdata_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata
);

  localparam int unsigned TW = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t      state_q;
  arb_owner_t      owner_q;
  mem_cmd_t        cmd_q, cmd_d;
  logic [TW-1:0]   tcnt_q;
  logic [1:0]      gnt;
  logic            rd_ret, tmo;
  logic            mem_ren_q, mem_wen_q;
  logic            f_rvalid_q, f_rerr_q, d_rvalid_q, d_rerr_q;
  logic [DATA_WIDTH-1:0] f_rdata_q, d_rdata_q;

  bc_arb_prio #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_prio (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_idle (state_q == IDLE),
    .i_f_req(i_f_req),
    .i_d_req(i_d_req),
    .o_gnt  (gnt)
  );

  assign o_f_gnt = gnt[GNT_F];
  assign o_d_gnt = gnt[GNT_D];

  always_comb begin
    cmd_d = '0;
    if (gnt[GNT_D]) begin
      cmd_d.we    = i_d_we;
      cmd_d.addr  = CMD_AW'(i_d_addr);
      cmd_d.wdata = CMD_DW'(i_d_wdata);
    end else begin
      cmd_d.addr  = CMD_AW'(i_f_addr);
    end
  end

  // Read data is only accepted while a read is actually in flight.
  assign rd_ret = i_mem_rdata_valid &&
                  (((state_q == ISSUE) && !cmd_q.we) || (state_q == WAIT));
  assign tmo    = (TIMEOUT != 0) && (state_q == WAIT) && !i_mem_rdata_valid &&
                  (tcnt_q == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      cmd_q      <= '0;
      tcnt_q     <= '0;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      f_rvalid_q <= 1'b0;
      f_rerr_q   <= 1'b0;
      f_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rerr_q   <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      f_rvalid_q <= 1'b0;
      f_rerr_q   <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_rerr_q   <= 1'b0;

      if (rd_ret || tmo) begin
        if (owner_q == OWN_DATA) begin
          d_rvalid_q <= 1'b1;
          d_rerr_q   <= tmo;
          d_rdata_q  <= tmo ? '0 : i_mem_rdata;
        end else begin
          f_rvalid_q <= 1'b1;
          f_rerr_q   <= tmo;
          f_rdata_q  <= tmo ? '0 : i_mem_rdata;
        end
      end

      case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q   <= gnt[GNT_D] ? OWN_DATA : OWN_FETCH;
            cmd_q     <= cmd_d;
            mem_ren_q <= !cmd_d.we;
            mem_wen_q <= cmd_d.we;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_q.we || i_mem_rdata_valid) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
            tcnt_q  <= TCNT_LOAD;
          end
        end
        WAIT: begin
          if (i_mem_rdata_valid || tmo) state_q <= IDLE;
          else if (tcnt_q != '0)        tcnt_q  <= tcnt_q - TW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_mem_ren         = mem_ren_q;
  assign o_mem_raddr       = ADDR_WIDTH'(cmd_q.addr);
  assign o_mem_wen         = mem_wen_q;
  assign o_mem_wdata_valid = mem_wen_q;
  assign o_mem_waddr       = ADDR_WIDTH'(cmd_q.addr);
  assign o_mem_wdata       = DATA_WIDTH'(cmd_q.wdata);
  assign o_f_rvalid        = f_rvalid_q;
  assign o_f_rerr          = f_rerr_q;
  assign o_f_rdata         = f_rdata_q;
  assign o_d_rvalid        = d_rvalid_q;
  assign o_d_rerr          = d_rerr_q;
  assign o_d_rdata         = d_rdata_q;

endmodule

// File: doc/bc_mem_arbiter.md
# bc_mem_arbiter

Two-requester arbiter that shares one word-addressed memory port between the instruction-fetch stage (read-only) and the data/load-store stage (read/write). It sits between the pipeline stages and the memory model/controller. Only one transaction is outstanding at a time. Data has priority, with a starvation guard for fetch and a read-timeout recovery path.

## Interface
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 32: word address width; consecutive addresses are consecutive words.
- `MAX_DATA_BURST`, 4: consecutive data grants allowed while fetch is waiting, 1..15.
- `TIMEOUT`, 16: cycles to wait in WAIT for read data; 0 disables the timeout.
- `i_clk` in 1: single clock, rising edge.
- `i_rstn` in 1: asynchronous, active-low reset.
- `i_f_req` in 1: fetch read request.
- `i_f_addr` in ADDR_WIDTH: fetch address.
- `o_f_gnt` out 1: fetch request accepted.
- `o_f_rvalid` out 1: fetch read data valid.
- `o_f_rdata` out DATA_WIDTH: fetch read data.
- `o_f_rerr` out 1: fetch read timed out.
- `i_d_req` in 1: data request.
- `i_d_we` in 1: 1 = write, 0 = read.
- `i_d_addr` in ADDR_WIDTH: data address.
- `i_d_wdata` in DATA_WIDTH: write data.
- `o_d_gnt` out 1: data request accepted.
- `o_d_rvalid` out 1: data read data valid.
- `o_d_rdata` out DATA_WIDTH: data read data.
- `o_d_rerr` out 1: data read timed out.
- `o_mem_ren` out 1: memory read strobe.
- `o_mem_raddr` out ADDR_WIDTH: memory read address.
- `i_mem_rdata` in DATA_WIDTH: memory read data.
- `i_mem_rdata_valid` in 1: memory read data valid.
- `o_mem_wen` out 1: memory write enable.
- `o_mem_wdata_valid` out 1: memory write data valid.
- `o_mem_waddr` out ADDR_WIDTH: memory write address.
- `o_mem_wdata` out DATA_WIDTH: memory write data.

## Operation
- **FSM states**
  - IDLE: arbitrate.
  - ISSUE: drive the memory command for one cycle.
  - WAIT: a read is outstanding.
- **Transitions**
  - IDLE → ISSUE when any request is present.
  - ISSUE → IDLE for a write.
  - ISSUE → WAIT for a read, unless `i_mem_rdata_valid` is high in ISSUE; in that case ISSUE → IDLE and the read completes.
  - WAIT → IDLE on `i_mem_rdata_valid` or on timeout.
- **Arbitration in IDLE**
  - Data wins by default.
  - Fetch wins if `burst_cnt == MAX_DATA_BURST` and `i_f_req` is high.
  - `burst_cnt` increments on a data grant while `i_f_req` is high.
  - `burst_cnt` clears on a fetch grant, or in any IDLE cycle with `i_f_req` low.
- **Request side**
  - `o_*_gnt` is combinational and pulses for one cycle in IDLE only.
  - The requester holds req, addr, we and wdata stable until it sees gnt; at gnt the arbiter latches the command and records the owner.
  - A fetch request is always a read.
- **Memory side**
  - Memory command outputs are registered and asserted only during ISSUE.
  - Read: `o_mem_ren=1`, `o_mem_raddr=addr`.
  - Write: `o_mem_wen=1`, `o_mem_wdata_valid=1`, `o_mem_waddr`/`o_mem_wdata` from the latched command.
  - Writes are posted; there is no response to the requester.
- **Read return**
  - `i_mem_rdata_valid` in ISSUE or WAIT is routed to the owner as registered `o_*_rvalid`/`o_*_rdata` one cycle later.
  - `i_mem_rdata_valid` in IDLE is ignored.
- **Timeout**
  - A counter runs in WAIT. When it reaches `TIMEOUT` with no valid, the owner gets `o_*_rvalid=1`, `o_*_rerr=1`, `o_*_rdata=0` next cycle, and the FSM returns to IDLE.
  - A late `i_mem_rdata_valid` is then dropped.
- **Reset**
  - All outputs are 0. State is IDLE; `burst_cnt`, the timeout counter and the owner are 0.
  - Reset mid-transaction abandons the transaction with no rvalid.

## Timing
- Read: gnt in cycle N, `o_mem_ren` in N+1. With 1-cycle memory, `i_mem_rdata_valid` arrives in N+2 and `o_*_rvalid` in N+3.
- The next gnt is possible in N+3.
- Write: gnt in N, `o_mem_wen` in N+1, next gnt in N+2.
- Throughput is at most one write per 2 cycles and one read per 3 cycles (1-cycle memory).
- The `o_*_rvalid`, `o_*_rerr` and `o_mem_*` strobes are single-cycle pulses.
- gnt and rvalid for different transactions may coincide; they are independent.

## Structure
- Package `bc_mem_arb_pkg` holds:
  - `arb_state_t` (IDLE/ISSUE/WAIT)
  - `arb_owner_t` (OWN_FETCH/OWN_DATA)
  - a packed `mem_cmd_t` {we, addr, wdata}
- Sub-module `bc_arb_prio`: combinational grant selection plus the `burst_cnt` register. It takes the requests and the IDLE flag and returns the grant vector.

## Test plan
- **Fetch-only read:** preload addr 0x1 = 0x0000_0214 and raise `i_f_req` with addr 0x1. Required: `o_f_gnt` in N, `o_mem_ren` with raddr 0x1 in N+1, `o_f_rvalid` with rdata 0x0000_0214 in N+3, `o_d_rvalid` never asserted.
- **Data write then read:** write 0xAAAA_AAAD to addr 0x5, then read addr 0x5. Required: `o_mem_wen`/`o_mem_wdata_valid` for one cycle, then `o_d_rdata` = 0xAAAA_AAAD.
- **Simultaneous requests:** raise `i_f_req` and `i_d_req` in the same cycle. Required: data granted first and fetch granted in the next IDLE.
- **Starvation:** hold `i_d_req` continuously with `MAX_DATA_BURST=4`. Required: 4 data grants, then 1 fetch grant, then data resumes.
- **Timeout:** memory never returns valid and `TIMEOUT=16`. Required: `o_d_rerr`=1 with rdata 0 after 16 WAIT cycles; a valid injected later produces no rvalid.
- **Reset during WAIT:** assert `i_rstn=0`. Required: all outputs 0 immediately, no rvalid after release, and a new request is served normally.
